// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - triggered circular capture of an ADC sample stream with valid/ready readout
//
// Purpose:
//   Records the registered ADC sample stream into a circular buffer. Once armed,
//   it first fills a pre-trigger window, then waits for a threshold/slope
//   crossing (or a forced trigger). It keeps capturing until the record is
//   complete, then streams the frozen record out, oldest sample first.
//
// Ports:
//   clk_pin_p     in   sole clock, rising edge
//   rst_pin       in   synchronous, active-high reset
//   sample_in     in   ADC sample, qualified by sample_valid
//   sample_valid  in   one-cycle qualifier for sample_in
//   arm           in   one-cycle capture start request (honoured only when idle)
//   trig_level    in   trigger threshold, held stable while armed
//   trig_slope    in   0 = rising crossing, 1 = falling crossing
//   force_trig    in   make the next valid sample the trigger sample
//   busy          out  capture or readout in progress
//   triggered     out  trigger seen, record not yet fully read out
//   rd_data       out  record sample
//   rd_valid      out  rd_data valid
//   rd_ready      in   consumer accepts rd_data
//   rd_last       out  final sample of the record, qualified by rd_valid

module adc_trig_capture #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int PRE_TRIG   = 16
) (
    input  logic              clk_pin_p,
    input  logic              rst_pin,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              force_trig,
    output logic              busy,
    output logic              triggered,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_POST    = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;

    // Offset from the trigger address back to the first record sample.
    localparam logic [DEPTH_LOG2-1:0] PRE_OFF   = DEPTH_LOG2'(PRE_TRIG);
    // Fill count value at which the last pre-trigger sample is being written.
    localparam logic [DEPTH_LOG2-1:0] FILL_LAST = DEPTH_LOG2'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    // Samples still to capture after the trigger sample.
    localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(DEPTH - PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] POST_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      RD_TOTAL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      RD_FINAL  = CNT_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]            state_q,      state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,     wr_ptr_d;
    logic [DEPTH_LOG2-1:0] fill_cnt_q,   fill_cnt_d;
    logic [DATA_W-1:0]     prev_q,       prev_d;
    logic                  prev_ok_q,    prev_ok_d;
    logic                  force_pend_q, force_pend_d;
    logic [DEPTH_LOG2-1:0] start_addr_q, start_addr_d;
    logic [DEPTH_LOG2-1:0] post_cnt_q,   post_cnt_d;
    logic                  triggered_q,  triggered_d;

    // Readout pipeline: RAM output stage (s1) feeding a one-deep output register.
    logic [CNT_W-1:0]      issue_cnt_q,  issue_cnt_d;
    logic                  s1_v_q,       s1_v_d;
    logic                  s1_last_q,    s1_last_d;
    logic                  out_v_q,      out_v_d;
    logic                  out_last_q,   out_last_d;
    logic [DATA_W-1:0]     out_data_q,   out_data_d;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     ram_q;

    logic                  wr_en;
    logic                  rd_issue;
    logic                  out_adv;
    logic                  level_hit;
    logic                  fire;
    logic [DEPTH_LOG2-1:0] rd_addr;

    assign rd_addr = start_addr_q + issue_cnt_q[DEPTH_LOG2-1:0];

    // Crossing test against the previous valid sample; unsigned compares.
    always_comb begin
        level_hit = 1'b0;
        if (prev_ok_q) begin
            if (!trig_slope) begin
                level_hit = (prev_q < trig_level) && (sample_in >= trig_level);
            end else begin
                level_hit = (prev_q > trig_level) && (sample_in <= trig_level);
            end
        end
    end

    // A forced trigger and a level crossing on the same sample are one trigger.
    assign fire = sample_valid && (force_trig || force_pend_q || level_hit);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        force_pend_d = force_pend_q;
        start_addr_d = start_addr_q;
        post_cnt_d   = post_cnt_q;
        triggered_d  = triggered_q;
        issue_cnt_d  = issue_cnt_q;
        s1_v_d       = s1_v_q;
        s1_last_d    = s1_last_q;
        out_v_d      = out_v_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        wr_en        = 1'b0;
        rd_issue     = 1'b0;
        out_adv      = !out_v_q || rd_ready;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    wr_ptr_d     = '0;
                    fill_cnt_d   = '0;
                    prev_ok_d    = 1'b0;
                    force_pend_d = 1'b0;
                    triggered_d  = 1'b0;
                    issue_cnt_d  = '0;
                    s1_v_d       = 1'b0;
                    out_v_d      = 1'b0;
                    out_last_d   = 1'b0;
                    state_d      = (PRE_TRIG == 0) ? S_ARMED : S_PREFILL;
                end
            end

            S_PREFILL: begin
                // Crossings here are ignored: the pre-trigger window is not yet full.
                if (sample_valid) begin
                    wr_en      = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (sample_valid) begin
                    wr_en = 1'b1;
                end
                if (fire) begin
                    // The trigger sample lands at wr_ptr_q and becomes record index PRE_TRIG.
                    start_addr_d = wr_ptr_q - PRE_OFF;
                    post_cnt_d   = POST_INIT;
                    triggered_d  = 1'b1;
                    force_pend_d = 1'b0;
                    state_d      = (POST_INIT == '0) ? S_READ : S_POST;
                end else if (force_trig) begin
                    force_pend_d = 1'b1;
                end
            end

            S_POST: begin
                if (sample_valid) begin
                    wr_en      = 1'b1;
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == POST_ONE) begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                // Issue a RAM read whenever the s1 slot is free or drains this cycle,
                // so the RAM latency is hidden and throughput is one per cycle.
                rd_issue = (issue_cnt_q != RD_TOTAL) && (!s1_v_q || out_adv);
                if (rd_issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    s1_v_d      = 1'b1;
                    s1_last_d   = (issue_cnt_q == RD_FINAL);
                end else if (out_adv) begin
                    s1_v_d = 1'b0;
                end

                // Output register only changes when empty or handshaking, which
                // keeps rd_data/rd_last stable under backpressure.
                if (out_adv) begin
                    out_v_d = s1_v_q;
                    if (s1_v_q) begin
                        out_data_d = ram_q;
                        out_last_d = s1_last_q;
                    end
                end

                if (out_v_q && rd_ready && out_last_q) begin
                    state_d     = S_IDLE;
                    triggered_d = 1'b0;
                    out_v_d     = 1'b0;
                    out_last_d  = 1'b0;
                    s1_v_d      = 1'b0;
                    issue_cnt_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            prev_d    = sample_in;
            prev_ok_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pin_p) begin
        if (rst_pin) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            force_pend_q <= 1'b0;
            start_addr_q <= '0;
            post_cnt_q   <= '0;
            triggered_q  <= 1'b0;
            issue_cnt_q  <= '0;
            s1_v_q       <= 1'b0;
            s1_last_q    <= 1'b0;
            out_v_q      <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            force_pend_q <= force_pend_d;
            start_addr_q <= start_addr_d;
            post_cnt_q   <= post_cnt_d;
            triggered_q  <= triggered_d;
            issue_cnt_q  <= issue_cnt_d;
            s1_v_q       <= s1_v_d;
            s1_last_q    <= s1_last_d;
            out_v_q      <= out_v_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    // Sample buffer: synchronous-read RAM, contents survive reset.
    always_ff @(posedge clk_pin_p) begin
        if (wr_en && !rst_pin) begin
            mem[wr_ptr_q] <= sample_in;
        end
        if (rd_issue && !rst_pin) begin
            ram_q <= mem[rd_addr];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign triggered = triggered_q;
    assign rd_valid  = out_v_q;
    assign rd_data   = out_data_q;
    assign rd_last   = out_last_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb/tb_adc_trig_capture.sv - self-checking bench for adc_trig_capture

module tb_adc_trig_capture;

    localparam int DW  = 8;
    localparam int DL2 = 4;
    localparam int PT  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          arm = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_slope = 1'b0;
    logic          force_trig = 1'b0;
    logic          busy;
    logic          triggered;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          rd_last;

    always #5 clk = ~clk;

    adc_trig_capture #(
        .DATA_W    (DW),
        .DEPTH_LOG2(DL2),
        .PRE_TRIG  (PT)
    ) dut (
        .clk_pin_p   (clk),
        .rst_pin     (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .arm         (arm),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .force_trig  (force_trig),
        .busy        (busy),
        .triggered   (triggered),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_last     (rd_last)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       slope;
        logic [7:0] level;
        logic [7:0] start;
        int         dir;
        int         period;
        int         force_at;
        int         arm_at;
        bit         rand_ready;
        logic [7:0] exp_first;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] val;
        logic [7:0] exp_d;
        logic [7:0] last_val;
        logic [7:0] held_d;
        logic       held_l;
        int         beats;
        int         sent_cyc;
        int         first_cyc;
        int         cyc;
        bit         stalled;
        bit         done;

        beats     = 0;
        sent_cyc  = -1;
        first_cyc = -1;
        cyc       = 0;
        stalled   = 1'b0;
        done      = 1'b0;
        held_d    = '0;
        held_l    = 1'b0;
        last_val  = v.exp_first + 8'(15 * v.dir);

        @(posedge clk); #1;
        arm          = 1'b1;
        trig_level   = v.level;
        trig_slope   = v.slope;
        sample_valid = 1'b0;
        force_trig   = 1'b0;
        rd_ready     = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
        val = v.start;

        while (!done && cyc < 600) begin
            sample_valid = ((cyc % v.period) == 0);
            sample_in    = sample_valid ? val : 8'h00;
            force_trig   = sample_valid && (v.force_at == int'(val));
            arm          = sample_valid && (v.arm_at == int'(val));
            if (sample_valid && val == last_val && sent_cyc < 0) sent_cyc = cyc;
            if (sample_valid) val = val + 8'(v.dir);
            rd_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            @(negedge clk);
            if (rd_valid && first_cyc < 0) begin
                first_cyc = cyc;
                check("rd_valid_latency", id, 32'((sent_cyc >= 0) && (first_cyc - sent_cyc <= 3)), 32'd1);
                check("triggered_in_read", id, 32'(triggered), 32'd1);
                check("busy_in_read", id, 32'(busy), 32'd1);
            end
            if (stalled) begin
                check("stall_valid", id, 32'(rd_valid), 32'd1);
                check("stall_data", id, 32'(rd_data), 32'(held_d));
                check("stall_last", id, 32'(rd_last), 32'(held_l));
            end
            if (rd_valid && rd_ready) begin
                exp_d = v.exp_first + 8'(beats * v.dir);
                check("rd_data", id, 32'(rd_data), 32'(exp_d));
                check("rd_last", id, 32'(rd_last), 32'(beats == 15));
                beats++;
                if (rd_last || beats >= 20) done = 1'b1;
            end
            stalled = rd_valid && !rd_ready;
            held_d  = rd_data;
            held_l  = rd_last;

            @(posedge clk); #1;
            cyc++;
        end

        sample_valid = 1'b0;
        force_trig   = 1'b0;
        arm          = 1'b0;
        rd_ready     = 1'b0;
        check("readout_done", id, 32'(done), 32'd1);
        check("beat_count", id, 32'(beats), 32'd16);
        @(negedge clk);
        check("busy_after_last", id, 32'(busy), 32'd0);
        check("triggered_after_last", id, 32'(triggered), 32'd0);
        check("rd_valid_after_last", id, 32'(rd_valid), 32'd0);
    endtask

    task automatic reset_mid_post();
        logic [7:0] val;
        logic [7:0] prev_drv;
        bit         seen;
        val      = 8'h00;
        prev_drv = 8'h00;
        seen     = 1'b0;

        @(posedge clk); #1;
        arm        = 1'b1;
        trig_level = 8'h20;
        trig_slope = 1'b0;
        force_trig = 1'b0;
        rd_ready   = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            sample_valid = 1'b1;
            sample_in    = val;
            @(negedge clk);
            if (triggered) begin
                seen = 1'b1;
                check("trig_sample", 100, 32'(prev_drv), 32'h20);
            end
            prev_drv = val;
            val      = val + 8'd1;
            @(posedge clk); #1;
        end
        check("trig_seen", 100, 32'(seen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_in    = val;
            val          = val + 8'd1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        @(negedge clk);
        check("still_busy_in_post", 100, 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 100, 32'(busy), 32'd0);
        check("rst_triggered", 100, 32'(triggered), 32'd0);
        check("rst_rd_valid", 100, 32'(rd_valid), 32'd0);
        check("rst_rd_last", 100, 32'(rd_last), 32'd0);
        check("rst_rd_data", 100, 32'(rd_data), 32'd0);
    endtask

    initial begin
        //             slope  level  start  dir period force arm_at rand exp_first
        vecs[0] = '{1'b0, 8'h20, 8'h00,  1, 1,   -1,   -1,   1'b0, 8'h1C}; // rising
        vecs[1] = '{1'b1, 8'h80, 8'hFF, -1, 1,   -1,   -1,   1'b0, 8'h84}; // falling
        vecs[2] = '{1'b0, 8'h02, 8'h00,  1, 1,    9,   -1,   1'b0, 8'h05}; // prefill ignore + force
        vecs[3] = '{1'b0, 8'h20, 8'h00,  1, 3,   -1,   -1,   1'b0, 8'h1C}; // valid gaps
        vecs[4] = '{1'b0, 8'h20, 8'h00,  1, 1,   -1,   -1,   1'b1, 8'h1C}; // backpressure
        vecs[5] = '{1'b0, 8'h20, 8'h00,  1, 1,   -1, 'h1E,   1'b0, 8'h1C}; // arm while armed

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", -1, 32'(busy), 32'd0);
        check("reset_triggered", -1, 32'(triggered), 32'd0);
        check("reset_rd_valid", -1, 32'(rd_valid), 32'd0);
        check("reset_rd_last", -1, 32'(rd_last), 32'd0);
        check("reset_rd_data", -1, 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        reset_mid_post();
        run_vec(6, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
